// File: rtl/rle_pkg.sv
// Shared definitions for the rle encoder and its job sequencer.
//   - Address/data geometry of the dual-port rle memory.
//   - Bit positions of the (count, value) pair inside a port-B read word.
//   - State encoding of the rle_ctrl sequencer FSM.
//   - Width of the settle/fetch wait counter.
package rle_pkg;

  localparam int RLE_ADDR_W   = 10;
  localparam int RLE_DATA_W   = 32;
  localparam int RLE_ADDR_MAX = 1023;

  localparam int RLE_CNT_HI = 15;
  localparam int RLE_CNT_LO = 8;
  localparam int RLE_VAL_HI = 7;
  localparam int RLE_VAL_LO = 0;

  localparam int RLE_WAIT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_FETCH  = 3'd3,
    ST_EMIT   = 3'd4
  } rle_ctrl_state_t;

endpackage

// File: rtl/rle_wait_cnt.sv
// Loadable down-counter used by rle_ctrl for both the settle wait and the
// port-B read-latency wait.
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   W-bit start value
//   done      out  counter has reached zero
module rle_wait_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rle_ctrl.sv
// Job sequencer for the dual-port rle encoder.
// Accepts a stream of 32-bit words, writes them to rle port A at addresses
// 1..N, waits a settle period, then walks rle port B from address 0 and
// emits each (count, value) pair as a valid/ready stream until the
// terminator pair (count 0) or the last address.
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_last      input word stream
//   out_valid/out_ready/out_count/out_value/out_last  encoded pair stream
//   busy, overflow              job status (overflow sticky until next job)
//   write_enable_a/addr_a/write_data_a     rle port-A write side
//   addr_b/read_data_b          rle port-B read side
//   fsm_state                   current FSM state (debug visibility)
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high; a producer holding valid keeps its payload
// stable and never drops valid until that transfer.
module rle_ctrl
  import rle_pkg::*;
#(
  parameter int SETTLE_CYCLES = 5,
  parameter int RD_LAT        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RLE_DATA_W-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_count,
  output logic [7:0]            out_value,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow,
  output logic                  write_enable_a,
  output logic [RLE_ADDR_W-1:0] addr_a,
  output logic [RLE_DATA_W-1:0] write_data_a,
  output logic [RLE_ADDR_W-1:0] addr_b,
  input  logic [RLE_DATA_W-1:0] read_data_b,
  output logic [2:0]            fsm_state
);

  localparam logic [RLE_ADDR_W-1:0] ADDR_LAST  = RLE_ADDR_W'(RLE_ADDR_MAX);
  localparam logic [RLE_WAIT_W-1:0] SETTLE_VAL = RLE_WAIT_W'(SETTLE_CYCLES);
  // FETCH lasts RD_LAT cycles: the counter reads zero in its final cycle.
  localparam logic [RLE_WAIT_W-1:0] FETCH_VAL  = RLE_WAIT_W'(RD_LAT - 1);

  rle_ctrl_state_t       state;
  logic                  accept;
  logic [RLE_ADDR_W-1:0] next_addr_a;
  logic                  at_limit;
  logic                  load_end;
  logic                  wait_load;
  logic [RLE_WAIT_W-1:0] wait_val;
  logic                  wait_done;
  logic                  unused_hi;

  // Upper half of the port-B word carries nothing for this controller.
  assign unused_hi = ^read_data_b[RLE_DATA_W-1:16];
  assign fsm_state = state;

  always_comb begin
    accept      = in_valid & in_ready;
    next_addr_a = (state == ST_IDLE) ? RLE_ADDR_W'(1) : addr_a + RLE_ADDR_W'(1);
    at_limit    = (state == ST_LOAD) && (next_addr_a == ADDR_LAST);
    load_end    = accept & (in_last | at_limit);
    wait_load   = 1'b0;
    wait_val    = '0;
    // The counter is loaded on the same edge the FSM enters SETTLE or FETCH.
    if (load_end) begin
      wait_load = 1'b1;
      wait_val  = SETTLE_VAL;
    end else if (((state == ST_SETTLE) && wait_done) ||
                 ((state == ST_EMIT) && out_ready && !out_last)) begin
      wait_load = 1'b1;
      wait_val  = FETCH_VAL;
    end
  end

  rle_wait_cnt #(.W(RLE_WAIT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wait_load),
    .load_val (wait_val),
    .done     (wait_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      in_ready       <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_count      <= '0;
      out_value      <= '0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      write_enable_a <= 1'b0;
      addr_a         <= '0;
      write_data_a   <= '0;
      addr_b         <= '0;
    end else begin
      write_enable_a <= 1'b0;
      case (state)
        ST_IDLE, ST_LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            write_enable_a <= 1'b1;
            addr_a         <= next_addr_a;
            write_data_a   <= in_data;
            busy           <= 1'b1;
            if (state == ST_IDLE) overflow <= 1'b0;
            if (at_limit) overflow <= 1'b1;
            if (load_end) begin
              state    <= ST_SETTLE;
              in_ready <= 1'b0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          if (wait_done) begin
            addr_b <= '0;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (wait_done) begin
            out_count <= read_data_b[RLE_CNT_HI:RLE_CNT_LO];
            out_value <= read_data_b[RLE_VAL_HI:RLE_VAL_LO];
            out_last  <= (read_data_b[RLE_CNT_HI:RLE_CNT_LO] == 8'd0) ||
                         (addr_b == ADDR_LAST);
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              addr_b <= addr_b + RLE_ADDR_W'(1);
              state  <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
